// File: rtl/seq_divider_param_if.sv
// Handshake/operand bundle between the ALU sequencer (master) and the sequential divider (slave).
// signed_mode exists only when SEQ_DIV_SIGNED_EN is defined.
interface seq_divider_param_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
`ifdef SEQ_DIV_SIGNED_EN
    logic             signed_mode;

    modport master (
        output start, dividend, divisor, signed_mode,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor, signed_mode,
        output busy, done, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
`endif
endinterface

// File: rtl/seq_divider_param.sv
// Multicycle restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional two's-complement mode is enabled by defining SEQ_DIV_SIGNED_EN.
module seq_divider_param #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    seq_divider_param_if.slave bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] shq_q, shq_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step, q_step;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] q_final, r_final;

    assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));

    // Stored remainder is always below the divisor, so its top bit is only needed transiently.
    always_comb begin
        shifted  = {rem_q, shq_q[WIDTH-1]};
        trial    = shifted - {1'b0, divisor_q};
        rem_step = shifted[WIDTH-1:0];
        q_step   = {shq_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_step = trial[WIDTH-1:0];
            q_step   = {shq_q[WIDTH-2:0], 1'b1};
        end
    end

`ifdef SEQ_DIV_SIGNED_EN
    logic q_neg_q, q_neg_d;
    logic r_neg_q, r_neg_d;
    logic dvd_neg, dvs_neg;

    // Core runs on magnitudes; result signs are remembered at accept and applied on completion.
    always_comb begin
        dvd_neg = bus.signed_mode & bus.dividend[WIDTH-1];
        dvs_neg = bus.signed_mode & bus.divisor[WIDTH-1];
        dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
        dvs_mag = dvs_neg ? -bus.divisor : bus.divisor;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        if (accept) begin
            q_neg_d = dvd_neg ^ dvs_neg;
            r_neg_d = dvd_neg;
        end
        q_final = q_neg_q ? -q_step : q_step;
        r_final = r_neg_q ? -rem_step : rem_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end
`else
    assign dvd_mag = bus.dividend;
    assign dvs_mag = bus.divisor;
    assign q_final = q_step;
    assign r_final = rem_step;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        shq_d       = shq_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    dbz_d     = 1'b0;
                    divisor_d = dvs_mag;
                    if (bus.divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = RUN;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        rem_d   = '0;
                        shq_d   = dvd_mag;
                    end
                end
            end
            RUN: begin
                rem_d = rem_step;
                shq_d = q_step;
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    quotient_d  = q_final;
                    remainder_d = r_final;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            shq_q       <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            shq_q       <= shq_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_param.sv
// Scoreboard bench for seq_divider_param: expected results queued at stimulus, compared on done.
// Signed checks are compiled in when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_divider_param;
    localparam int W        = 8;
    localparam int MAX_WAIT = 40;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_divider_param_if #(.WIDTH(W)) bus_if ();

    seq_divider_param #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sm;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           acc_cycle;
        int           lat;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    tests_run    = 0;
    int    tests_failed = 0;
    int    cycle        = 0;
    exp_t  mon_e;
    string mon_tag;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        exp_t e;
        int   sa, sb;
        e.a = a; e.b = b; e.sm = sm; e.acc_cycle = 0;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 0;
        end else if (sm) begin
            sa = $signed(a);
            sb = $signed(b);
            e.q = W'(sa / sb); e.r = W'(sa % sb); e.dbz = 1'b0; e.lat = W;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = W;
        end
        return e;
    endfunction

    // Result monitor: samples just after each rising edge and retires one scoreboard entry per done.
    always begin
        @(posedge clk);
        #1;
        if (bus_if.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                checkOutput({mon_tag, "_q"}, 32'(bus_if.quotient), 32'(mon_e.q));
                checkOutput({mon_tag, "_r"}, 32'(bus_if.remainder), 32'(mon_e.r));
                checkOutput({mon_tag, "_dbz"}, 32'(bus_if.div_by_zero), 32'(mon_e.dbz));
                checkOutput({mon_tag, "_lat"}, 32'(cycle - mon_e.acc_cycle), 32'(mon_e.lat));
                if (!mon_e.sm && mon_e.b != '0) begin
                    checkOutput({mon_tag, "_inv"},
                                32'(bus_if.quotient) * 32'(mon_e.b) + 32'(bus_if.remainder), 32'(mon_e.a));
                    checkOutput({mon_tag, "_rlt"}, 32'(bus_if.remainder < mon_e.b), 32'd1);
                end
            end
        end
    end

    task automatic applyStimulus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sm, input logic expect_done);
        exp_t e;
        bus_if.dividend = a;
        bus_if.divisor  = b;
`ifdef SEQ_DIV_SIGNED_EN
        bus_if.signed_mode = sm;
`endif
        bus_if.start = 1'b1;
        if (expect_done) begin
            e = model(a, b, sm);
            e.acc_cycle = cycle + 1;
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
    endtask

    task automatic waitDone(output int busy_cycles, input logic drop_start);
        bit seen;
        busy_cycles = 0;
        seen = 0;
        for (int i = 0; i < MAX_WAIT && !seen; i++) begin
            @(negedge clk);
            if (drop_start) bus_if.start = 1'b0;
            if (bus_if.done === 1'b1) seen = 1;
            else if (bus_if.busy === 1'b1) busy_cycles++;
        end
        if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        int bc;
        applyStimulus(tag, a, b, sm, 1'b1);
        waitDone(bc, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bc;
        logic [W-1:0] ra, rb;

        rst_n           = 1'b0;
        bus_if.start    = 1'b0;
        bus_if.dividend = '0;
        bus_if.divisor  = '0;
`ifdef SEQ_DIV_SIGNED_EN
        bus_if.signed_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(bus_if.busy), 32'd0);
        checkOutput("rst_done", 32'(bus_if.done), 32'd0);
        checkOutput("rst_q", 32'(bus_if.quotient), 32'd0);
        checkOutput("rst_r", 32'(bus_if.remainder), 32'd0);
        checkOutput("rst_dbz", 32'(bus_if.div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus("t1_200_7", 8'd200, 8'd7, 1'b0, 1'b1);
        waitDone(bc, 1'b1);
        checkOutput("t1_busy_cycles", 32'(bc), 32'd8);
        repeat (3) @(negedge clk);
        checkOutput("t1_hold_done", 32'(bus_if.done), 32'd0);
        checkOutput("t1_hold_q", 32'(bus_if.quotient), 32'd28);
        checkOutput("t1_hold_r", 32'(bus_if.remainder), 32'd4);

        applyStimulus("t2_255_1", 8'd255, 8'd1, 1'b0, 1'b1);
        waitDone(bc, 1'b0);
        applyStimulus("t2_5_9", 8'd5, 8'd9, 1'b0, 1'b1);
        @(negedge clk);
        bus_if.start = 1'b0;
        checkOutput("t2_b2b_busy", 32'(bus_if.busy), 32'd1);
        waitDone(bc, 1'b1);
        @(negedge clk);

        applyStimulus("t3_77_0", 8'd77, 8'd0, 1'b0, 1'b1);
        waitDone(bc, 1'b1);
        checkOutput("t3_dbz_busy", 32'(bc), 32'd0);
        @(negedge clk);
        checkOutput("t3_dbz_held", 32'(bus_if.div_by_zero), 32'd1);
        applyStimulus("t3_9_3", 8'd9, 8'd3, 1'b0, 1'b1);
        @(negedge clk);
        bus_if.start = 1'b0;
        checkOutput("t3_dbz_clear", 32'(bus_if.div_by_zero), 32'd0);
        waitDone(bc, 1'b1);
        @(negedge clk);

        applyStimulus("t4_100_3", 8'd100, 8'd3, 1'b0, 1'b1);
        @(negedge clk);
        bus_if.start    = 1'b0;
        bus_if.dividend = 8'd55;
        bus_if.divisor  = 8'd5;
        repeat (2) @(negedge clk);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        waitDone(bc, 1'b1);
        @(negedge clk);

        applyStimulus("t4_abort", 8'd10, 8'd2, 1'b0, 1'b0);
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("t4_abort_busy", 32'(bus_if.busy), 32'd0);
        checkOutput("t4_abort_done", 32'(bus_if.done), 32'd0);
        checkOutput("t4_abort_q", 32'(bus_if.quotient), 32'd0);
        checkOutput("t4_abort_r", 32'(bus_if.remainder), 32'd0);
        checkOutput("t4_abort_dbz", 32'(bus_if.div_by_zero), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("t4_after_q", 32'(bus_if.quotient), 32'd0);

`ifdef SEQ_DIV_SIGNED_EN
        runOp("t5_m7_2", 8'hF9, 8'd2, 1'b1);
        runOp("t5_7_m2", 8'd7, 8'hFE, 1'b1);
        runOp("t5_min_m1", 8'h80, 8'hFF, 1'b1);
        runOp("t5_m5_0", 8'hFB, 8'd0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            runOp("t5_rand", ra, rb, 1'b1);
        end
`endif

        runOp("t6_0_1", 8'd0, 8'd1, 1'b0);
        runOp("t6_255_255", 8'd255, 8'd255, 1'b0);
        runOp("t6_254_255", 8'd254, 8'd255, 1'b0);
        runOp("t6_255_2", 8'd255, 8'd2, 1'b0);
        runOp("t6_128_128", 8'd128, 8'd128, 1'b0);
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ((i % 50) == 7) rb = '0;
            runOp("t6_rand", ra, rb, 1'b0);
        end

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
